// File: rtl/data_memory_param.sv
// ---------------------------------------------------------------------------
// data_memory_param
//
// Block-organised data memory that models a slow backing store. A request
// (read or write, one at a time) is latched in IDLE, the memory then stalls
// the requester for a fixed number of cycles, performs the access on the
// final BUSY edge and shows a one-cycle DONE state in which busywait is low
// and the requester picks up readdata / retires its request.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-low reset
//   read       block read request (level, held until busywait drops)
//   write      block write request (level, held until busywait drops)
//   address    block address; only the low DEPTH_LOG2 bits select a block
//   writedata  write block, byte k at bits [8k+7:8k]
//   byteenable per-byte write enable
//   readdata   registered read block, changes only on read completion
//   busywait   stall to the requester
//   error      one-cycle pulse after a simultaneous read+write request
// ---------------------------------------------------------------------------
module data_memory_param #(
    parameter int ADDR_WIDTH    = 28,
    parameter int DEPTH_LOG2    = 4,
    parameter int BLOCK_BYTES   = 16,
    parameter int READ_LATENCY  = 5,
    parameter int WRITE_LATENCY = 5,
    localparam int BLOCK_BITS   = 8 * BLOCK_BYTES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   read,
    input  logic                   write,
    input  logic [ADDR_WIDTH-1:0]  address,
    input  logic [BLOCK_BITS-1:0]  writedata,
    input  logic [BLOCK_BYTES-1:0] byteenable,
    output logic [BLOCK_BITS-1:0]  readdata,
    output logic                   busywait,
    output logic                   error
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WRITE_LOAD = CNT_W'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       counter;
    logic                   op_write;
    logic [DEPTH_LOG2-1:0]  op_index;
    logic [BLOCK_BITS-1:0]  op_data;
    logic [BLOCK_BYTES-1:0] op_enable;
    logic [BLOCK_BITS-1:0]  mem [DEPTH];

    logic accept;
    logic conflict;
    logic commit;

    // A legal request is exactly one of read/write; both together is flagged
    // as an error and otherwise ignored.
    assign accept   = (state == IDLE) && (read ^ write);
    assign conflict = (state == IDLE) && read && write;
    assign commit   = (state == BUSY) && (counter == '0);

    // The stall covers the request cycle itself plus every BUSY cycle, so the
    // requester sees latency+1 stalled cycles before DONE.
    assign busywait = accept || (state == BUSY);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (read ^ write) state_next = BUSY;
            BUSY:    if (counter == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture, latency countdown and the memory access itself. All
    // request fields are latched at accept so the requester may change its
    // inputs (or drop the request) while BUSY without affecting the access.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            counter   <= '0;
            op_write  <= 1'b0;
            op_index  <= '0;
            op_data   <= '0;
            op_enable <= '0;
            readdata  <= '0;
            error     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            error <= conflict;
            if (accept) begin
                op_write  <= write;
                op_index  <= address[DEPTH_LOG2-1:0];
                op_data   <= writedata;
                op_enable <= byteenable;
                counter   <= write ? WRITE_LOAD : READ_LOAD;
            end else if (state == BUSY && counter != '0) begin
                counter <= counter - 1'b1;
            end
            if (commit) begin
                if (op_write) begin
                    for (int k = 0; k < BLOCK_BYTES; k++) begin
                        if (op_enable[k]) begin
                            mem[op_index][8*k +: 8] <= op_data[8*k +: 8];
                        end
                    end
                end else begin
                    readdata <= mem[op_index];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_param.sv
// ---------------------------------------------------------------------------
// tb_data_memory_param
//
// Directed bench for data_memory_param. A timeline model (each accepted
// request completes a fixed number of edges later; DONE follows for one
// cycle) predicts busywait, error and readdata, and a compare process checks
// the default-parameter DUT against it on every falling edge. Directed
// sequences add hand-computed literal checks. A second instance with
// READ_LATENCY=1 / WRITE_LATENCY=9 checks the stall length under other
// parameters.
// ---------------------------------------------------------------------------
module tb_data_memory_param;

    localparam int RL = 5;
    localparam int WL = 5;

    logic         clock;
    logic         reset;
    logic         read;
    logic         write;
    logic [27:0]  address;
    logic [127:0] writedata;
    logic [15:0]  byteenable;
    logic [127:0] readdata;
    logic         busywait;
    logic         error;

    logic         read2;
    logic         write2;
    logic [27:0]  address2;
    logic [127:0] readdata2;
    logic         busywait2;
    logic         error2;

    int n_cmp  = 0;
    int n_fail = 0;

    data_memory_param dut (
        .clock      (clock),
        .reset      (reset),
        .read       (read),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .byteenable (byteenable),
        .readdata   (readdata),
        .busywait   (busywait),
        .error      (error)
    );

    data_memory_param #(
        .READ_LATENCY  (1),
        .WRITE_LATENCY (9)
    ) dut_sweep (
        .clock      (clock),
        .reset      (reset),
        .read       (read2),
        .write      (write2),
        .address    (address2),
        .writedata  (writedata),
        .byteenable (byteenable),
        .readdata   (readdata2),
        .busywait   (busywait2),
        .error      (error2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Overall time limit so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // ------------------------------------------------------------------
    // Reference model: an accepted request commits at edge accept+latency
    // and leaves DONE at the following edge; until commit the requester is
    // stalled, and with nothing pending busywait reflects read XOR write.
    // ------------------------------------------------------------------
    logic [127:0] m_mem [16];
    logic [127:0] m_rdata;
    logic         m_err;
    logic         pending;
    int           cyc;
    int           commit_edge;
    logic         p_write;
    logic [3:0]   p_idx;
    logic [127:0] p_data;
    logic [15:0]  p_be;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending = 1'b0;
            m_err   = 1'b0;
            m_rdata = '0;
            for (int i = 0; i < 16; i++) m_mem[i] = '0;
        end else begin
            cyc   = cyc + 1;
            m_err = 1'b0;
            if (pending) begin
                if (cyc == commit_edge) begin
                    if (p_write) begin
                        for (int k = 0; k < 16; k++)
                            if (p_be[k]) m_mem[p_idx][8*k +: 8] = p_data[8*k +: 8];
                    end else begin
                        m_rdata = m_mem[p_idx];
                    end
                end else if (cyc == commit_edge + 1) begin
                    pending = 1'b0;
                end
            end else if (read && write) begin
                m_err = 1'b1;
            end else if (read || write) begin
                pending     = 1'b1;
                p_write     = write;
                p_idx       = address[3:0];
                p_data      = writedata;
                p_be        = byteenable;
                commit_edge = cyc + (write ? WL : RL);
            end
        end
    end

    task automatic check_output(input string name, input logic [127:0] actual,
                                input logic [127:0] expected);
        n_cmp = n_cmp + 1;
        if (actual !== expected) begin
            n_fail = n_fail + 1;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clock) begin
        logic exp_busy;
        exp_busy = pending ? (cyc < commit_edge) : (read ^ write);
        check_output("model_busywait", 128'(busywait), 128'(exp_busy));
        check_output("model_error",    128'(error),    128'(m_err));
        check_output("model_readdata", readdata,       m_rdata);
    end

    // Issue one request on the default DUT starting just after a rising
    // edge; counts stalled cycles and captures readdata in the DONE cycle,
    // where the request is dropped.
    task automatic apply_stimulus(input logic rd, input logic wr, input logic [27:0] addr,
                                  input logic [127:0] data, input logic [15:0] be,
                                  output int stalls, output logic [127:0] done_rdata);
        bit got;
        read       = rd;
        write      = wr;
        address    = addr;
        writedata  = data;
        byteenable = be;
        stalls     = 0;
        got        = 0;
        done_rdata = 'x;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (busywait) begin
                stalls = stalls + 1;
            end else begin
                got        = 1;
                done_rdata = readdata;
                read       = 1'b0;
                write      = 1'b0;
            end
        end
        if (!got) begin
            n_cmp  = n_cmp + 1;
            n_fail = n_fail + 1;
            $display("[TB] FAIL done_timeout: actual=no DONE required=DONE within 40 cycles");
            read  = 1'b0;
            write = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    // Same handshake on the parameter-sweep instance, returning the stall.
    task automatic sweep_stall(input logic rd, input logic wr, output int stalls);
        bit got;
        read2  = rd;
        write2 = wr;
        stalls = 0;
        got    = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (busywait2) begin
                stalls = stalls + 1;
            end else begin
                got    = 1;
                read2  = 1'b0;
                write2 = 1'b0;
            end
        end
        if (!got) begin
            read2  = 1'b0;
            write2 = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    localparam logic [127:0] D1  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] D2  = 128'h00112233_44556677_8899AABB_AAAAAAAA;
    localparam logic [127:0] D3  = 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D;
    localparam logic [127:0] D4  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] AA  = {16{8'hAA}};
    localparam logic [127:0] X55 = {16{8'h55}};

    initial begin
        int           stalls;
        logic [127:0] rd_val;

        cyc        = 0;
        reset      = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        read2      = 1'b0;
        write2     = 1'b0;
        address    = '0;
        address2   = '0;
        writedata  = '0;
        byteenable = '0;

        repeat (3) @(posedge clock);
        #1;
        check_output("reset_readdata", readdata, '0);
        check_output("reset_busywait", 128'(busywait), 128'(0));
        check_output("reset_error", 128'(error), 128'(0));
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Read of a freshly reset block.
        apply_stimulus(1'b1, 1'b0, 28'd3, '0, '0, stalls, rd_val);
        check_output("read3_stall", 128'(stalls), 128'(6));
        check_output("read3_data", rd_val, '0);

        // Full-block write then read back.
        apply_stimulus(1'b0, 1'b1, 28'd5, D1, 16'hFFFF, stalls, rd_val);
        check_output("write5_stall", 128'(stalls), 128'(6));
        apply_stimulus(1'b1, 1'b0, 28'd5, '0, '0, stalls, rd_val);
        check_output("read5_data", rd_val, D1);

        // Partial write touching only the low four bytes.
        apply_stimulus(1'b0, 1'b1, 28'd5, AA, 16'h000F, stalls, rd_val);
        apply_stimulus(1'b1, 1'b0, 28'd5, '0, '0, stalls, rd_val);
        check_output("read5_partial", rd_val, D2);

        // Simultaneous read and write: error pulse, no stall, no access.
        read    = 1'b1;
        write   = 1'b1;
        address = 28'd5;
        writedata  = '0;
        byteenable = 16'hFFFF;
        @(negedge clock);
        check_output("conflict_busywait", 128'(busywait), 128'(0));
        @(posedge clock);
        #1;
        read  = 1'b0;
        write = 1'b0;
        @(negedge clock);
        check_output("conflict_error", 128'(error), 128'(1));
        check_output("conflict_readdata", readdata, D2);
        @(negedge clock);
        check_output("conflict_error_clear", 128'(error), 128'(0));
        @(posedge clock);
        #1;
        apply_stimulus(1'b1, 1'b0, 28'd5, '0, '0, stalls, rd_val);
        check_output("conflict_mem", rd_val, D2);

        // Address aliasing: 0x13 and 0x23 both land on block 3.
        apply_stimulus(1'b0, 1'b1, 28'h13, D3, 16'hFFFF, stalls, rd_val);
        apply_stimulus(1'b1, 1'b0, 28'd3, '0, '0, stalls, rd_val);
        check_output("alias_read3", rd_val, D3);
        apply_stimulus(1'b1, 1'b0, 28'h23, '0, '0, stalls, rd_val);
        check_output("alias_read23", rd_val, D3);

        // Inputs changed and request dropped while BUSY: latched write of
        // D4 to block 9 still completes.
        read       = 1'b0;
        write      = 1'b1;
        address    = 28'd9;
        writedata  = D4;
        byteenable = 16'hFFFF;
        @(posedge clock);
        #1;
        write      = 1'b0;
        address    = 28'd10;
        writedata  = AA;
        byteenable = 16'h0000;
        stalls = 0;
        for (int i = 0; i < 20 && busywait; i++) begin
            @(posedge clock);
            #1;
            stalls = stalls + 1;
        end
        check_output("dropped_write_busy", 128'(busywait), 128'(0));
        @(posedge clock);
        #1;
        apply_stimulus(1'b1, 1'b0, 28'd9, '0, '0, stalls, rd_val);
        check_output("dropped_write_read9", rd_val, D4);
        apply_stimulus(1'b1, 1'b0, 28'd10, '0, '0, stalls, rd_val);
        check_output("dropped_write_read10", rd_val, '0);

        // Reset during the second BUSY cycle of a write to block 7.
        write      = 1'b1;
        address    = 28'd7;
        writedata  = X55;
        byteenable = 16'hFFFF;
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
        write = 1'b0;
        #1;
        check_output("midreset_readdata", readdata, '0);
        check_output("midreset_busywait", 128'(busywait), 128'(0));
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        apply_stimulus(1'b1, 1'b0, 28'd7, '0, '0, stalls, rd_val);
        check_output("midreset_read7", rd_val, '0);
        check_output("midreset_read7_stall", 128'(stalls), 128'(6));
        apply_stimulus(1'b1, 1'b0, 28'd5, '0, '0, stalls, rd_val);
        check_output("midreset_read5", rd_val, '0);

        // Parameter sweep instance: READ_LATENCY=1, WRITE_LATENCY=9.
        sweep_stall(1'b1, 1'b0, stalls);
        check_output("sweep_read_stall", 128'(stalls), 128'(2));
        sweep_stall(1'b0, 1'b1, stalls);
        check_output("sweep_write_stall", 128'(stalls), 128'(10));

        repeat (2) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
